// File: rtl/parity_frame_pkg.sv
// Shared types and width helpers for the parity frame serializer.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } pf_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return cnt_w(data_w);
  endfunction

  function automatic int gap_cnt_w(input int gap_cycles);
    return cnt_w(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/parity_frame_shifter.sv
// DATA_W-bit load/shift-right register; q0 is the bit currently at the LSB.
module parity_frame_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              q0
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= d;
    end else if (shift) begin
      shreg <= {1'b0, shreg[DATA_W-1:1]};
    end
  end

  assign q0 = shreg[0];

endmodule

// File: rtl/parity_frame_serializer.sv
// Serializes a handshaken word LSB-first, appends a parity bit, then idles
// for GAP_CYCLES before accepting the next word.
//
// state  | meaning
// IDLE   | ready high, waiting for valid
// DATA   | shifting payload bits onto out
// PARITY | driving the latched parity bit, last high
// GAP    | out low for GAP_CYCLES cycles
import parity_frame_pkg::*;

module parity_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              frame,
  output logic              last
);

  localparam int BIT_W = bit_cnt_w(DATA_W);
  localparam int GAP_W = gap_cnt_w(GAP_CYCLES);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  pf_state_t        state, state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic             par_q;
  logic             load, shift;
  logic             sh_bit;
  logic             gap_done;
  logic             out_nxt, frame_nxt, last_nxt;

  parity_frame_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .shift (shift),
    .d     (data_in),
    .q0    (sh_bit)
  );

  assign ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    out_nxt   = 1'b0;
    frame_nxt = 1'b0;
    last_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          load      = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        out_nxt   = sh_bit;
        frame_nxt = 1'b1;
        shift     = 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = PARITY;
      end
      PARITY: begin
        out_nxt   = par_q;
        frame_nxt = 1'b1;
        last_nxt  = 1'b1;
        state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      out     <= 1'b0;
      frame   <= 1'b0;
      last    <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      frame <= frame_nxt;
      last  <= last_nxt;
      if (load) begin
        bit_cnt <= '0;
        // Parity is fixed at accept so later data_in changes cannot leak in.
        par_q   <= (^data_in) ^ (ODD_PARITY != 0);
      end else if (shift) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      logic [GAP_W-1:0] gap_cnt;

      // Down-counter loaded while in PARITY; GAP exits on terminal count.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          gap_cnt <= '0;
        end else if (state == PARITY) begin
          gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        end else if (state == GAP && gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      end

      assign gap_done = (gap_cnt == '0);
    end else begin : g_nogap
      assign gap_done = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Self-checking bench: table vectors, corner sequences and random words
// checked against a bit-level reference of the serial frame.
module tb_parity_frame_serializer;

  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [D-1:0] data0 = '0, data1 = '0;
  logic         valid0 = 1'b0, valid1 = 1'b0;
  logic         ready0, out0, frame0, last0;
  logic         ready1, out1, frame1, last1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_frame_serializer #(.DATA_W(D), .ODD_PARITY(0), .GAP_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn), .data_in(data0), .valid(valid0),
    .ready(ready0), .out(out0), .frame(frame0), .last(last0)
  );

  parity_frame_serializer #(.DATA_W(D), .ODD_PARITY(1), .GAP_CYCLES(0)) dut_odd (
    .clk(clk), .rstn(rstn), .data_in(data1), .valid(valid1),
    .ready(ready1), .out(out1), .frame(frame1), .last(last1)
  );

  typedef struct {
    logic         sel;
    logic [D-1:0] w;
    logic         par;
  } vec_t;

  function automatic logic [3:0] obs(input logic sel);
    return sel ? {out1, frame1, last1, ready1} : {out0, frame0, last0, ready0};
  endfunction

  function automatic int gap_of(input logic sel);
    return sel ? 0 : 1;
  endfunction

  // Reference parity: count the ones, even count -> 0 for even parity.
  function automatic logic ref_par(input logic [D-1:0] w, input logic odd);
    int ones = 0;
    for (int i = 0; i < D; i++) ones += int'(w[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {out,frame,last,ready}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [D-1:0] d);
    if (sel) begin valid1 = v; data1 = d; end
    else     begin valid0 = v; data0 = d; end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic do_accept(input logic sel, input logic [D-1:0] w, output bit ok);
    int n = 0;
    logic [3:0] o;
    drive(sel, 1'b1, w);
    o = obs(sel);
    while (o[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      o = obs(sel);
    end
    if (o[0] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: ready=%b expected 1 within 40 cycles", o[0]);
      drive(sel, 1'b0, w);
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1 drive(sel, 1'b0, ~w);
    ok = 1'b1;
  endtask

  // k counts edges after the accept edge; sampled on the following negedge.
  task automatic check_frame(input logic sel, input logic [D-1:0] w, input logic par,
                             input int pulse_at);
    int g = gap_of(sel);
    logic [3:0] exp;
    for (int k = 0; k <= D + 1 + g; k++) begin
      @(negedge clk);
      if (k == 0)          exp = 4'b0000;
      else if (k <= D)     exp = {w[k-1], 1'b1, 1'b0, 1'b0};
      else if (k == D + 1) exp = {par, 1'b1, 1'b1, 1'b0};
      else                 exp = 4'b0000;
      exp[0] = (k >= D + 1 + g);
      chk($sformatf("frame[%0d] w=%h k=%0d", sel, w, k), obs(sel), exp);
      if (pulse_at > 0 && k == pulse_at)     drive(sel, 1'b1, 8'h55);
      if (pulse_at > 0 && k == pulse_at + 1) drive(sel, 1'b0, 8'h55);
    end
  endtask

  task automatic run_frame(input logic sel, input logic [D-1:0] w, input logic par,
                           input int pulse_at);
    bit ok;
    do_accept(sel, w, ok);
    if (ok) check_frame(sel, w, par, pulse_at);
  endtask

  task automatic check_quiet(input logic sel, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, obs(sel), 4'b0001);
    end
  endtask

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] w;
    bit ok;
    int t0, t1;

    tv[0] = '{1'b0, 8'hA5, 1'b0};
    tv[1] = '{1'b0, 8'h07, 1'b1};
    tv[2] = '{1'b0, 8'hFF, 1'b0};
    tv[3] = '{1'b0, 8'h80, 1'b1};
    tv[4] = '{1'b0, 8'h3C, 1'b0};
    tv[5] = '{1'b1, 8'h00, 1'b1};
    tv[6] = '{1'b1, 8'hFF, 1'b1};
    tv[7] = '{1'b1, 8'h01, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_dut", obs(1'b0), 4'b0001);
    chk("reset_dut_odd", obs(1'b1), 4'b0001);
    rstn = 1'b1;
    check_quiet(1'b0, 2, "idle_after_reset");

    foreach (tv[i]) run_frame(tv[i].sel, tv[i].w, tv[i].par, 0);

    // Back-to-back with valid held high
    drive(1'b0, 1'b1, 8'h01);
    @(posedge clk);
    #1 t0 = cyc;
    data0 = 8'h03;
    check_frame(1'b0, 8'h01, 1'b1, 0);
    @(posedge clk);
    #1 t1 = cyc;
    drive(1'b0, 1'b0, 8'h00);
    chk("b2b_accept_period", ((t1 - t0) == 11) ? 4'b0001 : 4'b0000, 4'b0001);
    if ((t1 - t0) != 11) $display("FAIL b2b_period: got %0d cycles expected 11", t1 - t0);
    check_frame(1'b0, 8'h03, 1'b0, 0);
    check_quiet(1'b0, 3, "b2b_tail_quiet");

    // Mid-frame reset during payload bit 4 of F0
    do_accept(1'b0, 8'hF0, ok);
    repeat (6) @(negedge clk);
    chk("pre_reset_bit4", obs(1'b0), 4'b1100);
    #2 rstn = 1'b0;
    #1 chk("async_reset_now", obs(1'b0), 4'b0001);
    drive(1'b0, 1'b1, 8'h55);
    @(posedge clk);
    @(negedge clk);
    chk("no_handshake_in_reset", obs(1'b0), 4'b0001);
    drive(1'b0, 1'b0, 8'h00);
    rstn = 1'b1;
    check_quiet(1'b0, 4, "post_reset_quiet");
    run_frame(1'b0, 8'h81, 1'b0, 0);

    // Busy valid pulse inside DATA is ignored
    run_frame(1'b0, 8'hA5, 1'b0, 3);
    check_quiet(1'b0, 15, "busy_pulse_no_frame");

    // Randomized words against the reference parity
    for (int i = 0; i < 20; i++) begin
      w = D'($urandom);
      run_frame(1'b0, w, ref_par(w, 1'b0), 0);
      if ($urandom_range(0, 2) == 0) check_quiet(1'b0, $urandom_range(1, 3), "rand_idle");
    end
    for (int i = 0; i < 10; i++) begin
      w = D'($urandom);
      run_frame(1'b1, w, ref_par(w, 1'b1), 0);
    end
    check_quiet(1'b1, 2, "odd_final_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
